mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 16, giving the maximum BUSY cycles allowed without dbus_ack.
REQ-002 SHALL have one clock; reset is synchronous and active-high, named clk and reset.
REQ-003 Ports, in order (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  sync active-high reset
- mem_regwr  in  1  register-write enable from EX/MEM
- mem_dmen  in  1  data-memory access enable
- mem_memtoreg  in  1  write-back source select (1 = load data)
- mem_memwr  in  1  store (1) / load (0)
- mem_result  in  32  ALU result / effective address
- mem_rt  in  32  store data
- mem_regdst_addr  in  5  destination register
- mem_pc_i  in  32  instruction PC
- dbus_req  out  1  bus request
- dbus_we  out  1  bus write enable
- dbus_addr  out  32  bus address
- dbus_wdata  out  32  bus write data
- dbus_ack  in  1  bus completion
- dbus_rdata  in  32  bus read data
- mem_stall  out  1  freeze upstream stages, including the EX/MEM register
- wb_regwr  out  1  MEM/WB register-write enable
- wb_regdst_addr  out  5  MEM/WB destination register
- wb_wdata  out  32  MEM/WB write-back data
- wb_pc_o  out  32  MEM/WB PC
- mem_exc  out  1  one-cycle exception pulse
- mem_badaddr  out  32  faulting address

Function
REQ-004 SHALL implement an FSM with states IDLE and BUSY.
REQ-005 In IDLE with mem_dmen=0:
- mem_stall=0
- the next edge loads wb_* from mem_regwr, mem_regdst_addr, mem_result, mem_pc_i
- latency 1 cycle
REQ-006 In IDLE with mem_dmen=1:
- mem_stall=1 combinationally
- the next edge latches address, wdata and we, moves to BUSY, and loads a bubble (wb_regwr=0) into MEM/WB
REQ-007 In BUSY:
- dbus_req=1
- dbus_addr, dbus_wdata and dbus_we SHALL come from latched values and stay stable until the state is left
REQ-008 In BUSY with dbus_ack=1:
- mem_stall=0 in the same cycle
- the edge loads MEM/WB with wb_wdata = mem_memtoreg ? dbus_rdata : mem_result, plus mem_regwr, dest and PC
- FSM returns to IDLE
- minimum load/store latency 2 cycles
REQ-009 dbus_ack SHALL be ignored outside BUSY.
REQ-010 A timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-011 On reaching BUS_TIMEOUT-1 without ack:
- mem_stall=0 in that cycle
- the next edge loads a bubble into MEM/WB, pulses mem_exc for 1 cycle, loads mem_badaddr with the latched address, and returns to IDLE
REQ-012 If dbus_ack arrives in the final timeout cycle, ack SHALL win and no exception is raised.
REQ-013 dbus_req SHALL be 0 in IDLE; dbus_we and dbus_wdata are don't-care when dbus_req=0.
REQ-014 mem_exc SHALL be 0 except for single-cycle pulses; mem_badaddr holds its value until the next exception.

Reset
REQ-015 On reset:
- FSM = IDLE
- counter = 0
- all outputs 0, including mem_stall, dbus_req and all wb_*
REQ-016 A reset asserted during BUSY SHALL abort the access; dbus_req is 0 from the following cycle and no exception is raised.

Configuration
REQ-017 Macro MEM_ALIGN_CHECK_EN, when defined: in IDLE with mem_dmen=1 and mem_result[1:0]!=0:
- no bus request is issued
- mem_stall=0
- the next edge loads a bubble, pulses mem_exc, and sets mem_badaddr=mem_result
REQ-018 Macro MEM_ALIGN_CHECK_EN, when undefined: dbus_addr[1:0] SHALL be forced to 0 and no alignment exception exists.

Structure
REQ-019 Shared package core_pkg SHALL hold the FSM state type, the BUS_TIMEOUT default and the register-address width constant (5).
REQ-020 The MEM/WB register SHALL be a sub-module memwb_register with load and bubble inputs; the FSM, counter and bus interface stay in mem_stage.

Verification
REQ-021 Scenario: ALU op, mem_dmen=0, mem_result=0x00000055, dest=5
- next cycle: wb_regwr=1, wb_wdata=0x55, wb_regdst_addr=5
- mem_stall never asserted
REQ-022 Scenario: load from 0x00001000, ack on the 3rd BUSY cycle, rdata=0xDEADBEEF, memtoreg=1
- mem_stall high 3 cycles
- wb_wdata=0xDEADBEEF the cycle after ack
REQ-023 Scenario: store addr=0x2004, data=0x12345678, immediate ack
- dbus_we=1 with stable addr/data for 1 BUSY cycle
- wb_regwr=0 afterwards
REQ-024 Scenario: load with no ack, BUS_TIMEOUT=4
- mem_exc pulses after 4 BUSY cycles
- mem_badaddr equals the address
- wb_regwr=0
- next instruction proceeds
REQ-025 Scenario: reset asserted in the 2nd BUSY cycle
- next cycle: dbus_req=0, mem_stall=0, all wb_*=0, mem_exc=0
REQ-026 Scenario: with MEM_ALIGN_CHECK_EN, load at 0x1002
- dbus_req stays 0
- mem_exc=1 for one cycle
- mem_badaddr=0x00001002

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the memory stage: FSM state type, bus-timeout default and
// register-address width.
package core_pkg;

    localparam int unsigned BUS_TIMEOUT_DEFAULT = 16;
    localparam int unsigned REG_ADDR_W          = 5;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } mem_state_e;

endpackage

// File: rtl/memwb_register.sv
// MEM/WB pipeline register.
// Ports:
//   clk_i, reset_i   - clock, synchronous active-high reset
//   load_i           - capture new contents this edge (otherwise hold)
//   bubble_i         - when loading, insert an empty slot instead of the inputs
//   regwr_i, regdst_addr_i, wdata_i, pc_i - incoming write-back fields
//   regwr_o, regdst_addr_o, wdata_o, pc_o - registered write-back fields
module memwb_register
    import core_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  load_i,
    input  logic                  bubble_i,
    input  logic                  regwr_i,
    input  logic [REG_ADDR_W-1:0] regdst_addr_i,
    input  logic [31:0]           wdata_i,
    input  logic [31:0]           pc_i,
    output logic                  regwr_o,
    output logic [REG_ADDR_W-1:0] regdst_addr_o,
    output logic [31:0]           wdata_o,
    output logic [31:0]           pc_o
);

    logic                  regwr_q;
    logic [REG_ADDR_W-1:0] regdst_addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           pc_q;

    // A bubble clears every field so the slot is fully inert downstream.
    always_ff @(posedge clk_i) begin
        if (reset_i || (load_i && bubble_i)) begin
            regwr_q       <= 1'b0;
            regdst_addr_q <= '0;
            wdata_q       <= '0;
            pc_q          <= '0;
        end else if (load_i) begin
            regwr_q       <= regwr_i;
            regdst_addr_q <= regdst_addr_i;
            wdata_q       <= wdata_i;
            pc_q          <= pc_i;
        end
    end

    assign regwr_o       = regwr_q;
    assign regdst_addr_o = regdst_addr_q;
    assign wdata_o       = wdata_q;
    assign pc_o          = pc_q;

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: runs data-bus loads/stores through an IDLE/BUSY FSM with a bus
// timeout, stalls upstream while an access is outstanding, and feeds the MEM/WB register.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned accesses raise an exception
// instead of going to the bus; when undefined the bus address low bits are forced to 0).
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   mem_*                        - EX/MEM instruction fields
//   dbus_req/we/addr/wdata       - data bus request side
//   dbus_ack/rdata               - data bus response side
//   mem_stall                    - freeze upstream stages
//   wb_*                         - MEM/WB register outputs
//   mem_exc, mem_badaddr         - bus/alignment exception pulse and faulting address
module mem_stage
    import core_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_regwr,
    input  logic                  mem_dmen,
    input  logic                  mem_memtoreg,
    input  logic                  mem_memwr,
    input  logic [31:0]           mem_result,
    input  logic [31:0]           mem_rt,
    input  logic [REG_ADDR_W-1:0] mem_regdst_addr,
    input  logic [31:0]           mem_pc_i,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [31:0]           dbus_addr,
    output logic [31:0]           dbus_wdata,
    input  logic                  dbus_ack,
    input  logic [31:0]           dbus_rdata,
    output logic                  mem_stall,
    output logic                  wb_regwr,
    output logic [REG_ADDR_W-1:0] wb_regdst_addr,
    output logic [31:0]           wb_wdata,
    output logic [31:0]           wb_pc_o,
    output logic                  mem_exc,
    output logic [31:0]           mem_badaddr
);

    localparam int unsigned    CntW    = $clog2(BUS_TIMEOUT) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BUS_TIMEOUT - 1);

    mem_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            exc_q, exc_d;
    logic [31:0]     badaddr_q, badaddr_d;

    logic            stall;
    logic            wb_load;
    logic            wb_bubble;
    logic            misaligned;
    logic [31:0]     wb_wdata_in;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (mem_result[1:0] != 2'b00);
    assign dbus_addr  = addr_q;
`else
    assign misaligned = 1'b0;
    assign dbus_addr  = {addr_q[31:2], 2'b00};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        exc_d     = 1'b0;
        badaddr_d = badaddr_q;
        stall     = 1'b0;
        wb_load   = 1'b0;
        wb_bubble = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d   = '0;
                wb_load = 1'b1;
                if (mem_dmen) begin
                    wb_bubble = 1'b1;
                    if (misaligned) begin
                        exc_d     = 1'b1;
                        badaddr_d = mem_result;
                    end else begin
                        stall   = 1'b1;
                        addr_d  = mem_result;
                        wdata_d = mem_rt;
                        we_d    = mem_memwr;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                // Ack has priority over the final timeout cycle.
                if (dbus_ack) begin
                    wb_load = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    wb_load   = 1'b1;
                    wb_bubble = 1'b1;
                    exc_d     = 1'b1;
                    badaddr_d = addr_q;
                    state_d   = StIdle;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            exc_q     <= 1'b0;
            badaddr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            exc_q     <= exc_d;
            badaddr_q <= badaddr_d;
        end
    end

    // Read data only selected while an access is in flight, so a stray ack is ignored.
    assign wb_wdata_in = (state_q == StBusy && mem_memtoreg) ? dbus_rdata : mem_result;

    memwb_register u_memwb (
        .clk_i         (clk),
        .reset_i       (reset),
        .load_i        (wb_load),
        .bubble_i      (wb_bubble),
        .regwr_i       (mem_regwr),
        .regdst_addr_i (mem_regdst_addr),
        .wdata_i       (wb_wdata_in),
        .pc_i          (mem_pc_i),
        .regwr_o       (wb_regwr),
        .regdst_addr_o (wb_regdst_addr),
        .wdata_o       (wb_wdata),
        .pc_o          (wb_pc_o)
    );

    // Stall is combinational; masked during reset so all outputs read 0.
    assign mem_stall   = stall & ~reset;
    assign dbus_req    = (state_q == StBusy);
    assign dbus_we     = we_q;
    assign dbus_wdata  = wdata_q;
    assign mem_exc     = exc_q;
    assign mem_badaddr = badaddr_q;

endmodule
